// File: rtl/ex_pc_stack_unit.sv
// rtl/ex_pc_stack_unit.sv - execute-stage PC owner with return-address stack
//
// Purpose:
//   Holds the fetch program counter and resolves the PC source for the
//   instruction currently in EX (sequential, offset branch, absolute jump,
//   or return from a circular return-address stack). A redirect loads the
//   new PC on the next edge and raises a combinational flush that squashes
//   the two younger instructions in IF and ID.
//
// Optional feature:
//   STACK_ERROR_FLAGS_EN - when defined, stack_overflow / stack_underflow
//   are sticky flags set on a full push / empty pop and cleared by rst.
//   When undefined, both outputs are tied to 0.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   stall                    freezes pc, stack and flags
//   ex_valid                 ID/EX holds a real instruction
//   PR2_pc                   PC of the instruction in EX
//   PR2_sel_PC_src_*         PC-source selects (plus1/offset/const/stack)
//   PR2_push_stacks/pop      return-address stack controls
//   branch_cond              offset branch taken when 1
//   PR2_offset               signed branch offset
//   PR2_const_addr           absolute jump target
//   pc                       registered fetch PC
//   flush                    combinational squash of IF/ID and next ID/EX load
//   stack_count              valid stack entries (0..STACK_DEPTH)
//   stack_overflow/underflow sticky stack error flags

module ex_pc_stack_unit #(
   parameter int PC_LEN      = 12,
   parameter int OFFSET_LEN  = 8,
   parameter int STACK_DEPTH = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               stall,
   input  logic                               ex_valid,
   input  logic [PC_LEN-1:0]                  PR2_pc,
   input  logic                               PR2_sel_PC_src_plus1s,
   input  logic                               PR2_sel_PC_src_offsets,
   input  logic                               PR2_sel_PC_src_consts,
   input  logic                               PR2_sel_PC_src_stacks,
   input  logic                               PR2_push_stacks,
   input  logic                               PR2_pop_stacks,
   input  logic                               branch_cond,
   input  logic [OFFSET_LEN-1:0]              PR2_offset,
   input  logic [PC_LEN-1:0]                  PR2_const_addr,
   output logic [PC_LEN-1:0]                  pc,
   output logic                               flush,
   output logic [$clog2(STACK_DEPTH):0]       stack_count,
   output logic                               stack_overflow,
   output logic                               stack_underflow
);

   localparam int PW = $clog2(STACK_DEPTH);
   localparam int CW = PW + 1;

   // Circular return-address buffer. wr_ptr is the next slot to write;
   // the top of stack lives at wr_ptr-1.
   logic [PC_LEN-1:0] stack_mem [STACK_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [CW-1:0]     count_q;

   logic              active;
   logic [PW-1:0]     top_ptr;
   logic [PC_LEN-1:0] top_val;
   logic              stack_empty;
   logic              stack_full;
   logic [PC_LEN-1:0] ret_addr;
   logic [PC_LEN-1:0] offset_ext;
   logic [PC_LEN-1:0] offset_target;
   logic [PC_LEN-1:0] stack_target;
   logic [PC_LEN-1:0] target;
   logic              redirect_sel;
   logic              redirect;
   logic              do_push;
   logic              do_pop;

   // plus1 is the implicit default source; the select itself carries no
   // extra information once the other selects are decoded.
   logic              unused_plus1_sel;
   assign unused_plus1_sel = PR2_sel_PC_src_plus1s;

   assign active        = ex_valid & ~stall;
   assign top_ptr       = wr_ptr - PW'(1);
   assign top_val       = stack_mem[top_ptr];
   assign stack_empty   = (count_q == '0);
   assign stack_full    = (count_q == CW'(STACK_DEPTH));
   assign ret_addr      = PR2_pc + PC_LEN'(1);
   assign offset_ext    = PC_LEN'($signed(PR2_offset));
   assign offset_target = ret_addr + offset_ext;
   // An empty stack has no return address; fall through to the next PC.
   assign stack_target  = stack_empty ? ret_addr : top_val;

   assign do_push = active & PR2_push_stacks;
   assign do_pop  = active & PR2_pop_stacks;

   // Source priority: stacks > consts > taken offset > plus1.
   always_comb begin
      redirect_sel = 1'b0;
      target       = ret_addr;
      if (PR2_sel_PC_src_stacks) begin
         redirect_sel = 1'b1;
         target       = stack_target;
      end else if (PR2_sel_PC_src_consts) begin
         redirect_sel = 1'b1;
         target       = PR2_const_addr;
      end else if (PR2_sel_PC_src_offsets && branch_cond) begin
         redirect_sel = 1'b1;
         target       = offset_target;
      end
   end

   assign redirect = active & redirect_sel;
   assign flush    = redirect & ~rst;

   // PC and stack state. Reset has priority over any redirect or push in
   // the same cycle, so no stack write happens while rst is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc      <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
         for (int i = 0; i < STACK_DEPTH; i++) begin
            stack_mem[i] <= '0;
         end
      end else begin
         if (!stall) begin
            pc <= redirect ? target : pc + PC_LEN'(1);
         end
         if (do_push && do_pop && !stack_empty) begin
            // Call-and-return in one instruction: swap the top entry.
            stack_mem[top_ptr] <= ret_addr;
         end else if (do_push) begin
            // When full, wr_ptr already points at the oldest entry, so the
            // write naturally overwrites it and the count saturates.
            stack_mem[wr_ptr] <= ret_addr;
            wr_ptr            <= wr_ptr + PW'(1);
            if (!stack_full) begin
               count_q <= count_q + CW'(1);
            end
         end else if (do_pop && !stack_empty) begin
            wr_ptr  <= wr_ptr - PW'(1);
            count_q <= count_q - CW'(1);
         end
      end
   end

   assign stack_count = count_q;

`ifdef STACK_ERROR_FLAGS_EN
   logic overflow_q;
   logic underflow_q;

   // Sticky flags; only rst clears them. A push+pop on a full stack keeps
   // the count unchanged and is not an overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (do_push && !do_pop && stack_full) begin
            overflow_q <= 1'b1;
         end
         if (do_pop && stack_empty) begin
            underflow_q <= 1'b1;
         end
      end
   end

   assign stack_overflow  = overflow_q;
   assign stack_underflow = underflow_q;
`else
   assign stack_overflow  = 1'b0;
   assign stack_underflow = 1'b0;
`endif

endmodule
